pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline. It generates every per-stage stall and flush strobe consumed by the pipeline registers, fetch through write-back. It also arbitrates the single external memory fill port between the I-cache and D-cache miss handlers, with D-side priority. It detects load-use hazards and branch mispredictions, and includes a fill watchdog.

Parameters:
REG_ADDR_W, 5, architectural register index width
WAIT_CNT_W, 8, watchdog counter width; timeout when a fill exceeds 2**WAIT_CNT_W-1 cycles

Ports:
clk_i  in  1  clock
arst_i  in  1  reset, asynchronous, active-high
i_fill_req_i  in  1  I-cache miss, fill requested; level, held until serviced
d_fill_req_i  in  1  D-cache miss, fill requested; level, held until serviced
mem_done_i  in  1  external memory fill complete, 1-cycle pulse
load_ex_i  in  1  instruction in EX is a load
rd_ex_i  in  REG_ADDR_W  EX destination register
rs1_id_i  in  REG_ADDR_W  ID source 1
rs2_id_i  in  REG_ADDR_W  ID source 2
branch_mispred_i  in  1  EX resolved a mispredicted branch/jump
i_fill_grant_o  out  1  I-cache owns the fill port
d_fill_grant_o  out  1  D-cache owns the fill port
stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, stall_wb_o  out  1 each  hold the stage register
flush_id_o, flush_ex_o  out  1 each  clear the stage register to a bubble
fill_timeout_o  out  1  sticky watchdog error
stall_cycles_o  out  64  perf: cycles with stall_wb_o=1 (see optional feature)
flush_count_o  out  64  perf: mispredict flushes (see optional feature)

Behaviour:
- Reset (async, any state including mid-fill): state=IDLE; both grants 0; watchdog 0; fill_timeout_o 0; perf counters 0. All stall/flush outputs are combinational and evaluate to 0 when no requests are present.
- Fill FSM, registered, states IDLE, FILL_D, FILL_I, RELEASE:
  - IDLE: d_fill_req_i -> FILL_D; else i_fill_req_i -> FILL_I; else stay. A simultaneous I and D request goes to FILL_D.
  - FILL_D / FILL_I: the matching grant is 1, registered, from the first cycle in the state. mem_done_i -> RELEASE.
  - RELEASE: 1 cycle, both grants 0; -> IDLE unconditionally. Requesters drop req by the end of RELEASE. A still-pending I request (or a new one) is granted through IDLE on the next pass.
  - mem_done_i in IDLE or RELEASE is ignored.
- mem_stall = i_fill_req_i | d_fill_req_i | (state != IDLE). When mem_stall=1, all five stall outputs are 1, both flushes are forced to 0, and load-use is suppressed. Stages are frozen, so a pending mispredict or hazard is re-evaluated once the stall ends.
- Load-use, only when mem_stall=0: hazard = load_ex_i & rd_ex_i != 0 & (rd_ex_i == rs1_id_i | rd_ex_i == rs2_id_i). It drives stall_if_o=1, stall_id_o=1, flush_ex_o=1 for that cycle, with no other stalls.
- Mispredict, only when mem_stall=0: flush_id_o=1, flush_ex_o=1. It overrides load-use in the same cycle: stall_if_o and stall_id_o are 0, and the wrong-path load is squashed.
- Watchdog: counter clears on entering FILL_D/FILL_I and increments each cycle in those states, saturating. When it reaches all-ones, fill_timeout_o is set and stays 1 until reset. The FSM keeps waiting.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cycles_o increments on every cycle with stall_wb_o=1. flush_count_o increments on every cycle with flush_id_o=1. Both are 64-bit and wrap.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset, no requests -> all stall/flush/grant outputs 0; fill_timeout_o 0.
- d_fill_req_i=1 at cycle 0 -> all stalls 1 at cycle 0; d_fill_grant_o=1 from cycle 1; mem_done_i at cycle 5 -> grant 0 at cycle 6 (RELEASE). With req dropped, stalls are 0 at cycle 7.
- i_fill_req_i and d_fill_req_i both asserted in the same cycle -> D granted first. After D's RELEASE, IDLE then FILL_I; i_fill_grant_o=1 two cycles after D's grant drops.
- load_ex_i=1, rd_ex_i=5, rs2_id_i=5 -> stall_if/id=1, flush_ex=1 for one cycle. Same with rd_ex_i=0 -> no stall.
- Load-use hazard plus branch_mispred_i in the same cycle -> flush_id=1, flush_ex=1, stall_if/id=0. Same with d_fill_req_i=1 -> all stalls 1, flushes 0.
- WAIT_CNT_W=4, FILL_I with no mem_done_i -> fill_timeout_o rises after 15 cycles in FILL_I and stays 1 through a later mem_done_i. Assert arst_i mid-fill -> grants and fill_timeout_o are 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Fill-port handshake between the I/D cache miss handlers, external memory and the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic i_fill_req_i;
  logic d_fill_req_i;
  logic mem_done_i;
  logic i_fill_grant_o;
  logic d_fill_grant_o;

  // Requester/memory side
  modport master (
    output i_fill_req_i, d_fill_req_i, mem_done_i,
    input  i_fill_grant_o, d_fill_grant_o
  );

  // Controller side
  modport slave (
    input  i_fill_req_i, d_fill_req_i, mem_done_i,
    output i_fill_grant_o, d_fill_grant_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with D-priority fill arbitration and a fill watchdog.
// Optional 64-bit perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  pipeline_hazard_ctrl_if.slave fill,
  input  logic                  load_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  branch_mispred_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  stall_mem_o,
  output logic                  stall_wb_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic                  fill_timeout_o,
  output logic [63:0]           stall_cycles_o,
  output logic [63:0]           flush_count_o
);

  localparam int unsigned PERF_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_D  = 2'd1,
    FILL_I  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wdog_q, wdog_d;
  logic                  in_fill;
  logic                  enter_fill;
  logic                  mem_stall;
  logic                  load_use;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fill.d_fill_req_i)      state_d = FILL_D;
        else if (fill.i_fill_req_i) state_d = FILL_I;
      end
      FILL_D, FILL_I: if (fill.mem_done_i) state_d = RELEASE;
      RELEASE:        state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Grants are flopped from the next state so they are valid on the first cycle of a fill.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      fill.i_fill_grant_o <= 1'b0;
      fill.d_fill_grant_o <= 1'b0;
    end else begin
      fill.i_fill_grant_o <= (state_d == FILL_I);
      fill.d_fill_grant_o <= (state_d == FILL_D);
    end
  end

  assign in_fill    = (state_q == FILL_D) || (state_q == FILL_I);
  assign enter_fill = (state_q == IDLE) && (state_d != IDLE);

  // Watchdog restarts on each fill and saturates; the FSM itself keeps waiting on timeout.
  always_comb begin
    wdog_d = wdog_q;
    if (enter_fill)                                 wdog_d = '0;
    else if (in_fill && (wdog_q != {WAIT_CNT_W{1'b1}})) wdog_d = wdog_q + WAIT_CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wdog_q         <= '0;
      fill_timeout_o <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (in_fill && (wdog_d == {WAIT_CNT_W{1'b1}})) fill_timeout_o <= 1'b1;
    end
  end

  assign mem_stall = fill.i_fill_req_i | fill.d_fill_req_i | (state_q != IDLE);
  assign load_use  = load_ex_i && (rd_ex_i != '0) &&
                     ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));

  // Memory stall freezes everything; mispredict outranks load-use since the load is wrong-path.
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    stall_wb_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    if (mem_stall) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      stall_wb_o  = 1'b1;
    end else if (branch_mispred_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (load_use) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_wb_o) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (flush_id_o) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = PERF_W'(0);
  assign flush_count_o  = PERF_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (watchdog shrunk to WAIT_CNT_W=4).
module tb_pipeline_hazard_ctrl;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  arst;
  logic                  load_ex;
  logic [REG_ADDR_W-1:0] rd_ex, rs1_id, rs2_id;
  logic                  mispred;
  logic stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex, timeout;
  logic [63:0] stall_cycles, flush_count;

  int passed = 0;
  int total  = 0;

  pipeline_hazard_ctrl_if fill_bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .WAIT_CNT_W(WAIT_CNT_W)) dut (
    .clk_i(clk), .arst_i(arst), .fill(fill_bus),
    .load_ex_i(load_ex), .rd_ex_i(rd_ex), .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
    .branch_mispred_i(mispred),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .stall_wb_o(stall_wb),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .fill_timeout_o(timeout), .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex}
  wire [6:0] ctl   = {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex};
  wire [1:0] grant = {fill_bus.i_fill_grant_o, fill_bus.d_fill_grant_o};

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_MEM  = 7'b1111100;
  localparam logic [6:0] CTL_LU   = 7'b1100001;
  localparam logic [6:0] CTL_MISP = 7'b0000011;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    fill_bus.i_fill_req_i = 1'b0;
    fill_bus.d_fill_req_i = 1'b0;
    fill_bus.mem_done_i   = 1'b0;
    load_ex = 1'b0; rd_ex = '0; rs1_id = '0; rs2_id = '0; mispred = 1'b0;
    #2;
    total++; if (ctl !== CTL_NONE) $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_NONE); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else passed++;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    step();
    total++; if (grant !== 2'b00) $display("FAIL post_reset_grant got=%b exp=00", grant); else passed++;
  endtask

  task automatic test_d_fill();
    step(); fill_bus.d_fill_req_i = 1'b1; #1;
    total++; if (ctl !== CTL_MEM || grant !== 2'b00) $display("FAIL dfill_c0 ctl=%b grant=%b exp ctl=%b grant=00", ctl, grant, CTL_MEM); else passed++;
    step(); #1;
    total++; if (grant !== 2'b01) $display("FAIL dfill_c1_grant got=%b exp=01", grant); else passed++;
    repeat (3) step();
    step(); fill_bus.mem_done_i = 1'b1; #1;
    total++; if (grant !== 2'b01 || ctl !== CTL_MEM) $display("FAIL dfill_c5 grant=%b ctl=%b exp grant=01 ctl=%b", grant, ctl, CTL_MEM); else passed++;
    step(); fill_bus.mem_done_i = 1'b0; fill_bus.d_fill_req_i = 1'b0; #1;
    total++; if (grant !== 2'b00 || ctl !== CTL_MEM) $display("FAIL dfill_release grant=%b ctl=%b exp grant=00 ctl=%b", grant, ctl, CTL_MEM); else passed++;
    step(); #1;
    total++; if (ctl !== CTL_NONE || grant !== 2'b00) $display("FAIL dfill_c7 ctl=%b grant=%b exp all 0", ctl, grant); else passed++;
  endtask

  task automatic test_both_req();
    step(); fill_bus.i_fill_req_i = 1'b1; fill_bus.d_fill_req_i = 1'b1; #1;
    total++; if (ctl !== CTL_MEM) $display("FAIL both_c0_ctl got=%b exp=%b", ctl, CTL_MEM); else passed++;
    step(); #1;
    total++; if (grant !== 2'b01) $display("FAIL both_d_first got=%b exp=01", grant); else passed++;
    fill_bus.mem_done_i = 1'b1;
    step(); fill_bus.mem_done_i = 1'b0; fill_bus.d_fill_req_i = 1'b0; #1;
    total++; if (grant !== 2'b00) $display("FAIL both_release got=%b exp=00", grant); else passed++;
    step(); #1;
    total++; if (grant !== 2'b00 || ctl !== CTL_MEM) $display("FAIL both_idle grant=%b ctl=%b exp grant=00 ctl=%b", grant, ctl, CTL_MEM); else passed++;
    step(); #1;
    total++; if (grant !== 2'b10) $display("FAIL both_i_grant got=%b exp=10", grant); else passed++;
    fill_bus.mem_done_i = 1'b1;
    step(); fill_bus.mem_done_i = 1'b0; fill_bus.i_fill_req_i = 1'b0; #1;
    total++; if (grant !== 2'b00) $display("FAIL both_i_release got=%b exp=00", grant); else passed++;
    step(); #1;
    total++; if (ctl !== CTL_NONE) $display("FAIL both_done_ctl got=%b exp=%b", ctl, CTL_NONE); else passed++;
  endtask

  task automatic test_load_use();
    load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd3; rs2_id = 5'd5; #1;
    total++; if (ctl !== CTL_LU) $display("FAIL lu_rs2 got=%b exp=%b", ctl, CTL_LU); else passed++;
    rd_ex = 5'd0; rs2_id = 5'd0; #1;
    total++; if (ctl !== CTL_NONE) $display("FAIL lu_x0 got=%b exp=%b", ctl, CTL_NONE); else passed++;
    rd_ex = 5'd7; rs1_id = 5'd7; rs2_id = 5'd1; #1;
    total++; if (ctl !== CTL_LU) $display("FAIL lu_rs1 got=%b exp=%b", ctl, CTL_LU); else passed++;
    rs1_id = 5'd6; rs2_id = 5'd8; #1;
    total++; if (ctl !== CTL_NONE) $display("FAIL lu_nomatch got=%b exp=%b", ctl, CTL_NONE); else passed++;
    rs1_id = 5'd7; load_ex = 1'b0; #1;
    total++; if (ctl !== CTL_NONE) $display("FAIL lu_notload got=%b exp=%b", ctl, CTL_NONE); else passed++;
  endtask

  task automatic test_mispred();
    step(); mispred = 1'b1; #1;
    total++; if (ctl !== CTL_MISP) $display("FAIL misp_alone got=%b exp=%b", ctl, CTL_MISP); else passed++;
    load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd0; rs2_id = 5'd5; #1;
    total++; if (ctl !== CTL_MISP) $display("FAIL misp_over_lu got=%b exp=%b", ctl, CTL_MISP); else passed++;
    fill_bus.d_fill_req_i = 1'b1; #1;
    total++; if (ctl !== CTL_MEM) $display("FAIL misp_memstall got=%b exp=%b", ctl, CTL_MEM); else passed++;
    step(); fill_bus.mem_done_i = 1'b1;
    step(); fill_bus.mem_done_i = 1'b0; fill_bus.d_fill_req_i = 1'b0; #1;
    total++; if (ctl !== CTL_MEM) $display("FAIL misp_release_ctl got=%b exp=%b", ctl, CTL_MEM); else passed++;
    step(); #1;
    total++; if (ctl !== CTL_MISP) $display("FAIL misp_reeval got=%b exp=%b", ctl, CTL_MISP); else passed++;
    mispred = 1'b0; load_ex = 1'b0;
    fill_bus.mem_done_i = 1'b1;
    step(); fill_bus.mem_done_i = 1'b0; #1;
    total++; if (ctl !== CTL_NONE || grant !== 2'b00) $display("FAIL idle_done_ignored ctl=%b grant=%b exp all 0", ctl, grant); else passed++;
  endtask

  task automatic test_timeout();
    step(); fill_bus.i_fill_req_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(); #1;
      if (k == 1) begin
        total++; if (grant !== 2'b10) $display("FAIL to_grant got=%b exp=10", grant); else passed++;
      end
      if (k == 15) begin
        total++; if (timeout !== 1'b0) $display("FAIL to_early got=%b exp=0", timeout); else passed++;
      end
    end
    step(); #1;
    total++; if (timeout !== 1'b1) $display("FAIL to_rise got=%b exp=1", timeout); else passed++;
    fill_bus.mem_done_i = 1'b1;
    step(); fill_bus.mem_done_i = 1'b0; fill_bus.i_fill_req_i = 1'b0;
    step(); #1;
    total++; if (timeout !== 1'b1 || ctl !== CTL_NONE) $display("FAIL to_sticky timeout=%b ctl=%b exp timeout=1 ctl=0", timeout, ctl); else passed++;
    // Mid-fill async reset
    step(); fill_bus.i_fill_req_i = 1'b1;
    step(); step(); #1;
    total++; if (grant !== 2'b10) $display("FAIL arst_pre_grant got=%b exp=10", grant); else passed++;
    arst = 1'b1; #1;
    total++; if (grant !== 2'b00 || timeout !== 1'b0) $display("FAIL arst_mid grant=%b timeout=%b exp 00/0", grant, timeout); else passed++;
    fill_bus.i_fill_req_i = 1'b0;
    @(negedge clk); arst = 1'b0;
    step(); #1;
    total++; if (ctl !== CTL_NONE || grant !== 2'b00) $display("FAIL arst_after ctl=%b grant=%b exp all 0", ctl, grant); else passed++;
  endtask

  task automatic test_perf();
`ifndef HAZARD_PERF_CNT_EN
    total++; if (stall_cycles !== 64'd0 || flush_count !== 64'd0) $display("FAIL perf_tied stall=%0d flush=%0d exp 0/0", stall_cycles, flush_count); else passed++;
`else
    // After the mid-fill reset the counters restart; one stall cycle and one flush cycle follow.
    fill_bus.d_fill_req_i = 1'b1;
    step(); fill_bus.d_fill_req_i = 1'b0;
    arst = 1'b1; #1; arst = 1'b0;
    mispred = 1'b1;
    step(); mispred = 1'b0; #1;
    total++; if (stall_cycles !== 64'd0 || flush_count !== 64'd1) $display("FAIL perf_cnt stall=%0d flush=%0d exp 0/1", stall_cycles, flush_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_d_fill();
    test_both_req();
    test_load_use();
    test_mispred();
    test_timeout();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout_guard sim time exceeded");
    $fatal(1);
  end
endmodule
